// File: rtl/normalizer16.sv
// normalizer16 - multi-cycle left normalizer for 16-bit values.
//
// The operand is shifted left until its MSB is significant. Count reports the
// shift distance, so a later right shift by Count restores the operand.
// Coarse steps shift by 4 and fine steps by 1.
//
// Parameters:
//   COARSE_EN  1 = 4-bit coarse steps before 1-bit fine steps; 0 = fine only
//
// Optional feature macro: NORMALIZER16_SIGNED_EN
//   defined   : Signed=1 selects a signed normalize (stops at the first bit
//               that differs from the sign bit)
//   undefined : Signed is ignored and every operation is unsigned
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   Start   request, accepted only while Busy=0
//   In      operand, captured with Start
//   Signed  signed-normalize select, captured with Start
//   Busy    operation in flight (from the cycle after acceptance through Done)
//   Done    one-cycle result pulse
//   Out     normalized value, held until the next result
//   Count   shift distance 0..16
//   Zero    operand had no significant bit
module normalizer16 #(
  parameter bit COARSE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [15:0] In,
  input  logic        Signed,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Out,
  output logic [4:0]  Count,
  output logic        Zero
);

  typedef enum logic [1:0] {IDLE, COARSE, FINE, DONE} state_t;

  state_t      state, nxt;
  logic [15:0] sh;
  logic [4:0]  cnt;
  logic        deg;
  logic        shift4;
  logic        shift1;

`ifdef NORMALIZER16_SIGNED_EN
  logic mode;

  always_ff @(posedge clk) begin
    if (rst)                        mode <= 1'b0;
    else if (state == IDLE && Start) mode <= Signed;
  end

  // Signed: all-zeros and all-ones carry no significant bit.
  assign deg    = Signed ? (In == 16'h0000 || In == 16'hFFFF) : (In == 16'h0000);
  assign shift4 = mode ? (sh[15:11] == 5'h00 || sh[15:11] == 5'h1F)
                       : (sh[15:12] == 4'h0);
  assign shift1 = mode ? (sh[15] == sh[14]) : ~sh[15];
`else
  logic signed_unused;
  assign signed_unused = Signed;

  assign deg    = (In == 16'h0000);
  assign shift4 = (sh[15:12] == 4'h0);
  assign shift1 = ~sh[15];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state. With COARSE_EN=0 the COARSE state is still visited for one
  // cycle without shifting, so latency stays c+f+3 in both configurations.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (Start) nxt = deg ? DONE : COARSE;
      COARSE:  nxt = (COARSE_EN && shift4) ? COARSE : FINE;
      FINE:    nxt = shift1 ? FINE : DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      sh    <= 16'h0000;
      cnt   <= 5'd0;
      Out   <= 16'h0000;
      Count <= 5'd0;
      Zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (Start) begin
          sh   <= In;
          cnt  <= 5'd0;
          Zero <= deg;
          if (deg) begin
            // Result is ready next cycle; unsigned zero shifts out all 16 bits,
            // a signed all-sign operand keeps one sign bit.
            Out   <= In;
`ifdef NORMALIZER16_SIGNED_EN
            Count <= Signed ? 5'd15 : 5'd16;
`else
            Count <= 5'd16;
`endif
          end
        end
        COARSE: if (COARSE_EN && shift4) begin
          sh  <= {sh[11:0], 4'h0};
          cnt <= cnt + 5'd4;
        end
        FINE: begin
          if (shift1) begin
            sh  <= {sh[14:0], 1'b0};
            cnt <= cnt + 5'd1;
          end else begin
            Out   <= sh;
            Count <= cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer16.sv
// Testbench for normalizer16: two instances (COARSE_EN=1 and COARSE_EN=0)
// share stimulus; one is observed at a time. Table vectors, hand sequences
// for corner cases, then random operands against a behavioural model.
module tb_normalizer16;

`ifdef NORMALIZER16_SIGNED_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] In = 16'h0000;
  logic        Signed = 1'b0;

  logic        busy0, done0, zero0, busy1, done1, zero1;
  logic [15:0] out0, out1;
  logic [4:0]  cnt0, cnt1;

  normalizer16 #(.COARSE_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .Start(Start), .In(In), .Signed(Signed),
    .Busy(busy0), .Done(done0), .Out(out0), .Count(cnt0), .Zero(zero0));

  normalizer16 #(.COARSE_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .Start(Start), .In(In), .Signed(Signed),
    .Busy(busy1), .Done(done1), .Out(out1), .Count(cnt1), .Zero(zero1));

  always #5 clk = ~clk;

  logic        sel = 1'b0;
  wire         busy_s = sel ? busy1 : busy0;
  wire         done_s = sel ? done1 : done0;
  wire         zero_s = sel ? zero1 : zero0;
  wire  [15:0] out_s  = sel ? out1  : out0;
  wire  [4:0]  cnt_s  = sel ? cnt1  : cnt0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: count redundant leading bits directly from the operand.
  function automatic void model(input logic [15:0] v, input bit s_in, input bit fine_only,
                                output logic [15:0] o, output logic [4:0] c,
                                output bit z, output int lat);
    bit s;
    int n;
    s = s_in & SB;
    z = 1'b0;
    n = 0;
    if (!s && v == 16'h0000) begin
      o = 16'h0000; c = 5'd16; z = 1'b1; lat = 1; return;
    end
    if (s && (v == 16'h0000 || v == 16'hFFFF)) begin
      o = v; c = 5'd15; z = 1'b1; lat = 1; return;
    end
    if (!s) begin
      for (int i = 15; i >= 0 && !v[i]; i--) n++;
    end else begin
      for (int i = 14; i >= 0 && v[i] == v[15]; i--) n++;
    end
    o = v << n;
    c = 5'(n);
    lat = fine_only ? n + 3 : n / 4 + n % 4 + 3;
  endfunction

  // One operation on the selected instance. intr>0 pulses Start with 16'h0003
  // in that cycle (counted from the acceptance cycle 0).
  task automatic run_op(input bit f, input logic [15:0] v, input bit s,
                        input logic [15:0] eo, input logic [4:0] ec, input bit ez,
                        input int elat, input int intr, input string nm);
    int k;
    bit busy_ok;
    sel = f;
    @(negedge clk);
    chk({nm, "_idle_busy"}, busy_s, 0);
    chk({nm, "_idle_done"}, done_s, 0);
    Start = 1'b1; In = v; Signed = s;
    k = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      Start = (k == intr);
      if (k == intr) In = 16'h0003;
      if (!busy_s) busy_ok = 1'b0;
    end while (!done_s && k < 40);
    chk({nm, "_latency"}, k, elat);
    chk({nm, "_busy"}, busy_ok, 1);
    chk({nm, "_out"}, out_s, eo);
    chk({nm, "_count"}, cnt_s, ec);
    chk({nm, "_zero"}, zero_s, ez);
  endtask

  typedef struct {
    logic [15:0] v;
    bit          s;
    logic [15:0] eo;
    logic [4:0]  ec;
    bit          ez;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [15:0] mo;
    logic [4:0]  mc;
    bit          mz;
    int          ml;
    logic [15:0] rv;
    bit          rs;

    tbl[0] = '{16'h0001, 1'b0, 16'h8000, 5'd15, 1'b0, 9};
    tbl[1] = '{16'h8000, 1'b0, 16'h8000, 5'd0,  1'b0, 3};
    tbl[2] = '{16'h0000, 1'b0, 16'h0000, 5'd16, 1'b1, 1};
    tbl[3] = '{16'h0010, 1'b0, 16'h8000, 5'd11, 1'b0, 8};
    if (SB) begin
      tbl[4] = '{16'hFFF0, 1'b1, 16'h8000, 5'd11, 1'b0, 8};
      tbl[5] = '{16'hFFFF, 1'b1, 16'hFFFF, 5'd15, 1'b1, 1};
      tbl[6] = '{16'h0000, 1'b1, 16'h0000, 5'd15, 1'b1, 1};
      tbl[7] = '{16'h4000, 1'b1, 16'h4000, 5'd0,  1'b0, 3};
    end else begin
      tbl[4] = '{16'hFFF0, 1'b1, 16'hFFF0, 5'd0,  1'b0, 3};
      tbl[5] = '{16'hFFFF, 1'b1, 16'hFFFF, 5'd0,  1'b0, 3};
      tbl[6] = '{16'h0000, 1'b1, 16'h0000, 5'd16, 1'b1, 1};
      tbl[7] = '{16'h4000, 1'b1, 16'h8000, 5'd1,  1'b0, 4};
    end

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_out0", out0, 16'h0000);
    chk("rst_count0", cnt0, 5'd0);
    chk("rst_zero0", zero0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_out1", out1, 16'h0000);

    // Table vectors, back to back
    foreach (tbl[i])
      run_op(1'b0, tbl[i].v, tbl[i].s, tbl[i].eo, tbl[i].ec, tbl[i].ez, tbl[i].lat, 0, "tbl");

    // Start during Busy is ignored
    run_op(1'b0, 16'h0010, 1'b0, 16'h8000, 5'd11, 1'b0, 8, 2, "busy_start");
    // Start in the DONE cycle is ignored; run_op's idle check sees Busy=0
    run_op(1'b0, 16'h8000, 1'b0, 16'h8000, 5'd0, 1'b0, 3, 3, "done_start");
    run_op(1'b0, 16'h0001, 1'b0, 16'h8000, 5'd15, 1'b0, 9, 0, "after_done");

    // Reset in cycle 4 of an operation
    @(negedge clk);
    Start = 1'b1; In = 16'h0001; Signed = 1'b0;
    @(negedge clk); Start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_out", out0, 16'h0000);
    chk("abort_count", cnt0, 5'd0);
    run_op(1'b0, 16'h0001, 1'b0, 16'h8000, 5'd15, 1'b0, 9, 0, "post_abort");

    // Random against the model, coarse instance
    for (int i = 0; i < 100; i++) begin
      rv = 16'($urandom >> $urandom_range(16, 32));
      if ($urandom_range(0, 1) == 1) rv = ~rv;
      rs = 1'($urandom_range(0, 1));
      model(rv, rs, 1'b0, mo, mc, mz, ml);
      run_op(1'b0, rv, rs, mo, mc, mz, ml, 0, "rnd_c");
    end

    // Let the fine-only instance drain before observing it
    repeat (25) @(negedge clk);
    run_op(1'b1, 16'h0001, 1'b0, 16'h8000, 5'd15, 1'b0, 18, 0, "fine_only");
    for (int i = 0; i < 60; i++) begin
      rv = 16'($urandom >> $urandom_range(16, 32));
      if ($urandom_range(0, 1) == 1) rv = ~rv;
      rs = 1'($urandom_range(0, 1));
      model(rv, rs, 1'b1, mo, mc, mz, ml);
      run_op(1'b1, rv, rs, mo, mc, mz, ml, 0, "rnd_f");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
